// File: rtl/aes_pkg.sv
// Shared AES constants for the SubBytes datapath: byte width, engine state
// encoding, forward S-box and (when AES_INV_SBOX_EN is defined) inverse S-box.
package aes_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // Forward S-box, index = input byte
  localparam logic [BYTE_W-1:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

`ifdef AES_INV_SBOX_EN
  // Inverse S-box, index = input byte
  localparam logic [BYTE_W-1:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
`endif

endpackage

// File: rtl/aes_sbox_lane.sv
// One byte-wide S-box lane: purely combinational table lookup.
// Build option: AES_INV_SBOX_EN adds the inverse table and the inv select;
// without it inv is ignored and the lane is forward-only.
// Ports: din  - byte in
//        inv  - 1 selects inverse S-box
//        dout - substituted byte
module aes_sbox_lane
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] din,
  input  logic              inv,
  output logic [BYTE_W-1:0] dout
);

`ifdef AES_INV_SBOX_EN
  assign dout = inv ? INV_SBOX[din] : SBOX[din];
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign dout       = SBOX[din];
`endif

endmodule

// File: rtl/aes_sub_bytes_engine.sv
// Handshaked AES SubBytes/InvSubBytes engine. One 128-bit state per
// transaction, LANES bytes substituted per cycle over 16/LANES beats.
// Build option: AES_INV_SBOX_EN enables InvSubBytes via in_inv; otherwise
// in_inv is ignored and every transaction is forward SubBytes.
// Ports: clk, rst_n (async active-low)
//        in_valid/in_ready/in_block/in_inv  - input handshake, byte i = [8i+7:8i]
//        out_valid/out_ready/out_block      - result handshake
//        busy                               - high while in SUB or DONE
module aes_sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   in_block,
  input  logic           in_inv,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   out_block,
  output logic           busy
);

  localparam int unsigned NBYTE     = 16;
  localparam int unsigned BLOCK_W   = NBYTE * BYTE_W;
  localparam int unsigned NBEAT     = NBYTE / LANES;
  localparam int unsigned BEAT_W    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEAT - 1);

  // Reject unsupported lane counts at elaboration
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("aes_sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  sub_state_t          state, state_nxt;
  logic [BEAT_W-1:0]   beat, beat_nxt;
  logic [BLOCK_W-1:0]  work, work_nxt, work_sub;
  logic                mode;
  logic                accept;
  logic [3:0]          base;

  logic [BYTE_W-1:0]   lane_din  [LANES];
  logic [BYTE_W-1:0]   lane_dout [LANES];

  // Input side may accept in IDLE, or in DONE in the same edge the result leaves
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_block = work;

  // First byte index handled this beat
  assign base = 4'(32'(beat) * LANES);

`ifdef AES_INV_SBOX_EN
  // Mode captured with the block it applies to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= 1'b0;
    end else if (accept) begin
      mode <= in_inv;
    end
  end
`else
  logic unused_in_inv;
  assign unused_in_inv = in_inv;
  assign mode          = 1'b0;
`endif

  // S-box lanes over the current beat's bytes
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign lane_din[j] = work[{base + 4'(j), 3'b000} +: BYTE_W];
    aes_sbox_lane u_lane (
      .din  (lane_din[j]),
      .inv  (mode),
      .dout (lane_dout[j])
    );
  end

  // Working register with this beat's bytes replaced
  always_comb begin
    work_sub = work;
    for (int j = 0; j < LANES; j++) begin
      work_sub[{base + 4'(j), 3'b000} +: BYTE_W] = lane_dout[j];
    end
  end

  // Next-state / datapath decode
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    work_nxt  = work;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SUB;
          beat_nxt  = '0;
          work_nxt  = in_block;
        end
      end
      SUB: begin
        work_nxt = work_sub;
        beat_nxt = beat + 1'b1;
        if (beat == LAST_BEAT) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (accept) begin
          state_nxt = SUB;
          beat_nxt  = '0;
          work_nxt  = in_block;
        end else if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat      <= '0;
      work      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      beat      <= beat_nxt;
      work      <= work_nxt;
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt != IDLE);
    end
  end

endmodule
